// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the block-copy memory initiator.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_master.sv
// Word-by-word block copy initiator on the data-memory port.
// Alternates read/write cycles and accumulates a checksum of words read.
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    csum_d  = csum_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          csum_d = '0;
          if (len != '0) begin
            src_d   = src_base;
            dst_d   = dst_base;
            len_d   = len;
            idx_d   = '0;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        data_d  = ReadData;
        csum_d  = csum_q + ReadData;
        state_d = WR;
      end
      WR: begin
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = RD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port outputs decode only registered state so they never follow inputs.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    unique case (1'b1)
      (state_q == RD): begin
        MemRead = 1'b1;
        Address = src_q + ADDR_W'(idx_q);
      end
      (state_q == WR): begin
        MemWrite  = 1'b1;
        Address   = dst_q + ADDR_W'(idx_q);
        WriteData = data_q;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign checksum = csum_q;

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Memory-port initiator that copies a block of words from a source region to a destination region of the word-addressed data memory. It drives the same MemRead/MemWrite/Address/WriteData/ReadData port that the data memory responds on, and sits beside the multicycle datapath. It is the initiator side for block moves and memory self-test, and reports a running checksum of the words it moved.

## Interface
Parameters:
- ADDR_W, 32, width of word address
- DATA_W, 32, width of data word
- LEN_W, 16, width of word-count input

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk in IDLE only
- src_base  input  ADDR_W  first source word address, captured on accepted start
- dst_base  input  ADDR_W  first destination word address, captured on accepted start
- len  input  LEN_W  number of words, captured on accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the transfer completes
- checksum  output  DATA_W  sum mod 2^DATA_W of all words read in the last or current transfer
- MemRead  output  1  read strobe to memory
- MemWrite  output  1  write strobe to memory
- Address  output  ADDR_W  word address to memory
- WriteData  output  DATA_W  write data to memory
- ReadData  input  DATA_W  combinational read data from memory, valid in the same cycle as Address/MemRead

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 and len≠0: capture src_base, dst_base and len; clear idx and checksum; go to RD.
  - start=1 and len=0: clear checksum; go to DONE.
- RD: MemRead=1, Address=src_reg+idx. At the clock edge, latch ReadData into data_reg and add it to checksum. Go to WR.
- WR: MemWrite=1, Address=dst_reg+idx, WriteData=data_reg. At the clock edge:
  - idx=len_reg−1: go to DONE.
  - otherwise: increment idx and go to RD.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. Base and length inputs may change freely after acceptance.
- Address arithmetic is modulo 2^ADDR_W, so an address past all-ones wraps to 0.
- Copy is forward, word by word. Overlapping regions with dst>src overwrite source words before they are read; this behaviour is defined and intended. dst=src rewrites each word with its own value.
- MemRead and MemWrite are never high in the same cycle. Both are low in IDLE and DONE.
- In IDLE and DONE, Address and WriteData are 0.
- checksum holds its value after DONE until the next accepted start.

## Timing
- Reset (asynchronous, any state, including mid-transfer): state=IDLE, idx=0, data_reg=0, checksum=0. All outputs return to 0 immediately.
- An aborted transfer leaves memory partially written. No write occurs at or after reset assertion.
- Strobes and Address are Moore outputs: decoded from registered state, idx and base registers only, never from inputs.
- For start accepted at edge k with len=N≥1:
  - cycles k+1 … k+2N alternate RD, WR;
  - done is high in cycle k+2N+1;
  - busy falls in cycle k+2N+2;
  - throughput is 2 cycles per word.
- For len=0: done is high in the cycle after acceptance, and no memory strobe occurs.
- Memory write takes effect on the rising edge that ends a WR cycle.

## Structure
- Shared package mem_copy_pkg holds the state enum (IDLE, RD, WR, DONE) and default widths.
- Single module; no sub-module is needed. The idx counter, base registers and checksum accumulator are inline.

## Test plan
- Preload words 100..103 with 0x11, 0x22, 0x33, 0x44; start with src=100, dst=200, len=4. Required response:
  - words 200..203 equal 0x11..0x44;
  - done is high exactly 9 cycles after the start edge;
  - checksum=0xAA;
  - strobes alternate read/write and never overlap.
- start with len=0. Required response: done in the next cycle, MemRead and MemWrite never high, checksum=0.
- Overlap: preload words 10..12 with 1, 2, 3; start with src=10, dst=11, len=2. Required response: words 11 and 12 both equal 1 (forward smear).
- Wrap: src=0xFFFFFFFF, len=2. Required response: reads at 0xFFFFFFFF then 0x00000000.
- Assert rst during the WR of word 2 of 5. Required response:
  - all outputs are 0 at once and state is IDLE;
  - destination words 0..1 are written and word 2 onward is unchanged;
  - a new start then completes normally.
- Pulse start again while busy. Required response: ignored, and the transfer completes with the original parameters.
